// File: rtl/kbd_pkg.sv
// Shared scan-code constants, frame geometry and small helpers for the
// PS/2 keyboard input responder.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_D0     = 8'h45;
  localparam logic [7:0] SC_D1     = 8'h16;
  localparam logic [7:0] SC_D2     = 8'h1E;
  localparam logic [7:0] SC_D3     = 8'h26;
  localparam logic [7:0] SC_D4     = 8'h25;
  localparam logic [7:0] SC_D5     = 8'h2E;
  localparam logic [7:0] SC_D6     = 8'h36;
  localparam logic [7:0] SC_D7     = 8'h3D;
  localparam logic [7:0] SC_D8     = 8'h3E;
  localparam logic [7:0] SC_D9     = 8'h46;

  localparam logic [3:0] FRAME_BITS = 4'd11;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_DATA = 1'b1
  } rx_state_e;

  // Returns {is_digit, value}; value is meaningless when is_digit is clear.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    case (code)
      SC_D0:   return {1'b1, 4'd0};
      SC_D1:   return {1'b1, 4'd1};
      SC_D2:   return {1'b1, 4'd2};
      SC_D3:   return {1'b1, 4'd3};
      SC_D4:   return {1'b1, 4'd4};
      SC_D5:   return {1'b1, 4'd5};
      SC_D6:   return {1'b1, 4'd6};
      SC_D7:   return {1'b1, 4'd7};
      SC_D8:   return {1'b1, 4'd8};
      SC_D9:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // frame = {stop, parity, data[7:0]}; valid needs stop=1 and odd parity.
  function automatic logic frame_ok(input logic [9:0] frame);
    return frame[9] & (^frame[8:0]);
  endfunction

endpackage

// File: rtl/kbd_input_if.sv
// CPU-side handshake of the keyboard responder: status in, word/control/overflow out.
interface kbd_input_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  status;
  logic [DATA_WIDTH-1:0] in;
  logic                  control;
  logic                  overflow;

  modport master (output status, input in, input control, input overflow);
  modport slave  (input status, output in, output control, output overflow);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the pins, samples on keyboard-clock falling
// edges, checks start/parity/stop and aborts stalled frames.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic            clk_meta_r, clk_sync_r, clk_prev_r;
  logic            data_meta_r, data_sync_r;
  rx_state_e       state_r;
  logic [3:0]      bit_cnt_r;
  logic [8:0]      shift_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [7:0]      code_r;
  logic            code_valid_r;
  logic            fall_s;
  logic [9:0]      frame_s;

  // Edge detect and the candidate frame as it would look with the current bit appended.
  always_comb begin
    fall_s  = clk_prev_r & ~clk_sync_r;
    frame_s = {data_sync_r, shift_r};
  end

  // Synchronizers, frame FSM and stall timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_r   <= 1'b1;
      clk_sync_r   <= 1'b1;
      clk_prev_r   <= 1'b1;
      data_meta_r  <= 1'b1;
      data_sync_r  <= 1'b1;
      state_r      <= RX_IDLE;
      bit_cnt_r    <= 4'd0;
      shift_r      <= 9'd0;
      to_cnt_r     <= {TO_W{1'b0}};
      code_r       <= 8'd0;
      code_valid_r <= 1'b0;
    end else begin
      clk_meta_r   <= ps2_clk;
      clk_sync_r   <= clk_meta_r;
      clk_prev_r   <= clk_sync_r;
      data_meta_r  <= ps2_data;
      data_sync_r  <= data_meta_r;
      code_valid_r <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          to_cnt_r  <= {TO_W{1'b0}};
          bit_cnt_r <= 4'd1;
          // A start bit of 1 is simply not a frame start.
          if (fall_s && !data_sync_r) begin
            state_r <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (fall_s) begin
            to_cnt_r <= {TO_W{1'b0}};
            if (bit_cnt_r == (FRAME_BITS - 4'd1)) begin
              state_r <= RX_IDLE;
              if (frame_ok(frame_s)) begin
                code_r       <= frame_s[7:0];
                code_valid_r <= 1'b1;
              end
            end else begin
              shift_r   <= {data_sync_r, shift_r[8:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else if (to_cnt_r == TO_LAST) begin
            state_r <= RX_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

  assign code       = code_r;
  assign code_valid = code_valid_r;

endmodule

// File: rtl/kbd_input.sv
// Keyboard input responder: decodes digit keys into a number, commits it on
// Enter into a FIFO and hands words to the CPU on its IN handshake.
module kbd_input
  import kbd_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  kbd_input_if.slave  cpu
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [7:0]            code_s;
  logic                  code_valid_s;
  logic [4:0]            digit_s;
  logic [DATA_WIDTH-1:0] acc_r, acc_next_s;
  logic                  brk_r, brk_next_s, ext_r, ext_next_s;
  logic                  push_req_s, push_s, pop_s, full_s;
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r, count_next_s;
  logic [DATA_WIDTH-1:0] in_r;
  logic                  control_r, overflow_r;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code_s),
    .code_valid (code_valid_s)
  );

  // Scan-code decoder: prefix flags, accumulator update and commit request.
  always_comb begin
    digit_s    = digit_lookup(code_s);
    acc_next_s = acc_r;
    brk_next_s = brk_r;
    ext_next_s = ext_r;
    push_req_s = 1'b0;
    if (code_valid_s) begin
      if (code_s == SC_BREAK) begin
        brk_next_s = 1'b1;
      end else if (code_s == SC_EXT) begin
        ext_next_s = 1'b1;
      end else if (brk_r || ext_r) begin
        brk_next_s = 1'b0;
        ext_next_s = 1'b0;
      end else if (digit_s[4]) begin
        acc_next_s = (acc_r << 3) + (acc_r << 1) + DATA_WIDTH'(digit_s[3:0]);
      end else if (code_s == SC_ENTER) begin
        push_req_s = 1'b1;
        acc_next_s = {DATA_WIDTH{1'b0}};
      end else if (code_s == SC_BKSP) begin
        acc_next_s = {DATA_WIDTH{1'b0}};
      end else begin
        acc_next_s = acc_r;
      end
    end else begin
      acc_next_s = acc_r;
    end
  end

  // FIFO control; a full FIFO still accepts a push when a pop frees a slot that edge.
  always_comb begin
    pop_s  = cpu.status & control_r;
    full_s = (count_r == CNT_FULL);
    push_s = push_req_s & (~full_s | pop_s);
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Decoder state, FIFO storage/pointers and registered CPU-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= {DATA_WIDTH{1'b0}};
      brk_r      <= 1'b0;
      ext_r      <= 1'b0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      in_r       <= {DATA_WIDTH{1'b0}};
      control_r  <= 1'b0;
      overflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      acc_r     <= acc_next_s;
      brk_r     <= brk_next_s;
      ext_r     <= ext_next_s;
      count_r   <= count_next_s;
      control_r <= (count_next_s != {CNT_W{1'b0}});
      if (push_s) begin
        mem_r[wr_ptr_r] <= acc_r;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        in_r     <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (push_req_s && !push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign cpu.in       = in_r;
  assign cpu.control  = control_r;
  assign cpu.overflow = overflow_r;

endmodule

// File: tb/tb_kbd_input.sv
// Self-checking bench for kbd_input: key tables, hand-built corner sequences
// and a randomized key stream checked against a queue-based reference model.
module tb_kbd_input;

  logic clk = 1'b0;
  logic rst_n, ps2_clk, ps2_data;
  int   checks = 0;
  int   failures = 0;

  kbd_input_if #(.DATA_WIDTH(16)) cpu_if ();

  kbd_input #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(5000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .cpu      (cpu_if)
  );

  always #5 clk = ~clk;

  // Reference model: number typed so far, committed-number queue, sticky overflow.
  int   m_acc;
  int   m_q[$];
  bit   m_brk, m_ext, m_ovf, model_on;
  logic [7:0] dig_code [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_q.delete(); m_brk = 0; m_ext = 0; m_ovf = 0;
  endtask

  task automatic model_code(input logic [7:0] c);
    int d;
    d = -1;
    for (int i = 0; i < 10; i++) if (dig_code[i] == c) d = i;
    if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE0) m_ext = 1;
    else if (m_brk || m_ext) begin m_brk = 0; m_ext = 0; end
    else if (d >= 0) m_acc = (m_acc * 10 + d) % 65536;
    else if (c == 8'h5A) begin
      if (m_q.size() < 4) m_q.push_back(m_acc); else m_ovf = 1;
      m_acc = 0;
    end
    else if (c == 8'h66) m_acc = 0;
  endtask

  // Sends nbits of a frame; pop_stop raises status for exactly the decode edge.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits, input bit pop_stop);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (pop_stop && i == 10 && k == 3) cpu_if.status = 1'b1;
        if (pop_stop && i == 10 && k == 4) cpu_if.status = 1'b0;
      end
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (6) @(negedge clk);
    if (model_on && nbits == 11 && !bad_par) model_code(code);
  endtask

  task automatic type_key(input logic [7:0] code, input bit ext, input bit pop_make);
    if (ext) send_frame(8'hE0, 0, 11, 0);
    send_frame(code, 0, 11, pop_make);
    if (ext) send_frame(8'hE0, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(code, 0, 11, 0);
  endtask

  task automatic pop();
    cpu_if.status = 1'b1;
    @(negedge clk);
    cpu_if.status = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [7:0]  keys [6];
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; cpu_if.status = 1'b0;
    model_on = 0; model_reset();
    repeat (3) @(negedge clk);
    check("reset_in", cpu_if.in, 0);
    check("reset_control", cpu_if.control, 0);
    check("reset_overflow", cpu_if.overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{3, '{8'h16, 8'h1E, 8'h26, 8'h00, 8'h00, 8'h00}, 16'd123};
    vecs[1] = '{5, '{8'h36, 8'h2E, 8'h2E, 8'h26, 8'h36, 8'h00}, 16'd0};
    vecs[2] = '{5, '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h00}, 16'd34463};
    vecs[3] = '{4, '{8'h16, 8'h1E, 8'h66, 8'h3D, 8'h00, 8'h00}, 16'd7};
    vecs[4] = '{4, '{8'h45, 8'h45, 8'h25, 8'h1E, 8'h00, 8'h00}, 16'd42};
    vecs[5] = '{3, '{8'h16, 8'h1C, 8'h2E, 8'h00, 8'h00, 8'h00}, 16'd15};
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n; k++) type_key(vecs[v].keys[k], 0, 0);
      type_key(8'h5A, 0, 0);
      check("tbl_control_up", cpu_if.control, 1);
      pop();
      check("tbl_in", cpu_if.in, vecs[v].exp);
      check("tbl_control_down", cpu_if.control, 0);
    end

    // Extended Enter must not commit; the pending 8 survives it.
    type_key(8'h3E, 0, 0);
    type_key(8'h5A, 1, 0);
    check("ext_enter_no_push", cpu_if.control, 0);
    type_key(8'h5A, 0, 0);
    pop();
    check("ext_enter_keeps_acc", cpu_if.in, 8);

    // Five commits into a four-deep FIFO.
    for (int n = 1; n <= 5; n++) begin
      type_key(dig_code[n], 0, 0);
      type_key(8'h5A, 0, 0);
    end
    check("ovf_control", cpu_if.control, 1);
    check("ovf_flag", cpu_if.overflow, 1);
    for (int n = 1; n <= 4; n++) begin
      pop();
      check("ovf_pop_order", cpu_if.in, n);
    end
    check("ovf_drained", cpu_if.control, 0);

    // Push into a full FIFO on the same edge as a pop.
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      type_key(dig_code[n], 0, 0);
      type_key(8'h5A, 0, 0);
    end
    type_key(dig_code[5], 0, 0);
    type_key(8'h5A, 0, 1);
    check("pushpop_in", cpu_if.in, 1);
    check("pushpop_no_ovf", cpu_if.overflow, 0);
    for (int n = 2; n <= 5; n++) begin
      check("pushpop_control", cpu_if.control, 1);
      pop();
      check("pushpop_order", cpu_if.in, n);
    end
    check("pushpop_count4", cpu_if.control, 0);

    // Bad-parity "7" between "4" and Enter.
    type_key(dig_code[4], 0, 0);
    send_frame(dig_code[7], 1, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(dig_code[7], 0, 11, 0);
    type_key(8'h5A, 0, 0);
    pop();
    check("parity_drop", cpu_if.in, 4);

    // Stalled partial frame must time out before the next key.
    send_frame(8'h46, 0, 5, 0);
    repeat (5100) @(negedge clk);
    type_key(dig_code[9], 0, 0);
    type_key(8'h5A, 0, 0);
    pop();
    check("timeout_recover", cpu_if.in, 9);
    check("timeout_empty", cpu_if.control, 0);

    // Reset in the middle of a frame with a word buffered.
    type_key(dig_code[7], 0, 0);
    type_key(8'h5A, 0, 0);
    send_frame(8'h46, 0, 5, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in", cpu_if.in, 0);
    check("rst_mid_control", cpu_if.control, 0);
    check("rst_mid_overflow", cpu_if.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized key stream against the reference model.
    model_reset();
    model_on = 1;
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 16);
      if (r <= 9) type_key(dig_code[r], 0, 0);
      else if (r <= 11) type_key(8'h5A, 0, 0);
      else if (r == 12) type_key(8'h66, 0, 0);
      else if (r == 13) type_key(8'h1C, 0, 0);
      else if (r == 14) type_key(8'h5A, 1, 0);
      else begin
        check("rnd_control", cpu_if.control, (m_q.size() != 0) ? 1 : 0);
        check("rnd_overflow", cpu_if.overflow, m_ovf);
        if (m_q.size() != 0) begin
          pop();
          check("rnd_in", cpu_if.in, m_q.pop_front());
        end
      end
    end
    type_key(8'h5A, 0, 0);
    check("rnd_final_overflow", cpu_if.overflow, m_ovf);
    while (m_q.size() != 0) begin
      check("rnd_drain_control", cpu_if.control, 1);
      pop();
      check("rnd_drain_in", cpu_if.in, m_q.pop_front());
    end
    check("rnd_empty", cpu_if.control, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
